// File: rtl/rgb_pwm_encoder_if.sv
// Duty-update bus between the colour sequencer (master) and rgb_pwm_encoder (slave).
interface rgb_pwm_encoder_if;
    logic [7:0] R_duty_in;
    logic [7:0] G_duty_in;
    logic [7:0] B_duty_in;
    logic       duty_valid;
    logic       duty_ack;

    modport master (
        output R_duty_in, G_duty_in, B_duty_in, duty_valid,
        input  duty_ack
    );

    modport slave (
        input  R_duty_in, G_duty_in, B_duty_in, duty_valid,
        output duty_ack
    );
endinterface

// File: rtl/rgb_pwm_encoder.sv
// rgb_pwm_encoder: three-channel 8-bit PWM generator with frame-aligned,
// double-buffered duty updates.
// Optional build macro: RGB_PWM_ACTIVE_LOW_EN inverts pwm_r/pwm_g/pwm_b
// (common-anode LEDs); frame_start and duty_ack keep their polarity.
module rgb_pwm_encoder #(
    parameter int unsigned PRESCALE = 244
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    rgb_pwm_encoder_if.slave duty_bus,
    output logic             pwm_r,
    output logic             pwm_g,
    output logic             pwm_b,
    output logic             frame_start
);
    localparam int unsigned DUTY_W = 8;
    localparam int unsigned RGB_W  = 3 * DUTY_W;
    localparam int unsigned PSC_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0]  PSC_LAST  = PSC_W'(PRESCALE - 1);
    localparam logic [DUTY_W-1:0] PCNT_LAST = DUTY_W'(254);
`ifdef RGB_PWM_ACTIVE_LOW_EN
    localparam logic PWM_INVERT = 1'b1;
`else
    localparam logic PWM_INVERT = 1'b0;
`endif
    localparam logic [2:0] PWM_OFF = {3{PWM_INVERT}};

    // IDLE: disabled or just out of reset; RUN: a frame has been launched.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PSC_W-1:0]  psc_q, psc_d;
    logic [DUTY_W-1:0] pcnt_q, pcnt_d;
    logic [RGB_W-1:0]  pend_q, pend_d;
    logic [RGB_W-1:0]  active_q, active_d;
    logic              pend_flag_q, pend_flag_d;
    logic              counting_c, tick_c, boundary_c, frame_go_c, xfer_c;
    logic [2:0]        pwm_on_c;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, counters, pending/active transfer and PWM compare.
    always_comb begin
        state_d     = state_q;
        psc_d       = psc_q;
        pcnt_d      = pcnt_q;
        pend_d      = pend_q;
        pend_flag_d = pend_flag_q;
        active_d    = active_q;
        pwm_on_c    = 3'b000;

        case (state_q)
            ST_IDLE: if (en)  state_d = ST_RUN;
            ST_RUN:  if (!en) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // The first enabled cycle only launches the frame, so the frame that
        // follows frame_start is a full 255 ticks long.
        counting_c = en && (state_q == ST_RUN);
        tick_c     = counting_c && (psc_q == PSC_LAST);
        boundary_c = tick_c && (pcnt_q == PCNT_LAST);
        frame_go_c = boundary_c || (en && (state_q == ST_IDLE));
        xfer_c     = pend_flag_q && (frame_go_c || !en);

        if (!counting_c) begin
            psc_d  = '0;
            pcnt_d = '0;
        end else if (tick_c) begin
            psc_d  = '0;
            pcnt_d = (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + DUTY_W'(1);
        end else begin
            psc_d  = psc_q + PSC_W'(1);
        end

        if (xfer_c) begin
            active_d = pend_q;
        end

        // A write landing on the transfer cycle stays pending for the next frame.
        if (duty_bus.duty_valid) begin
            pend_d      = {duty_bus.R_duty_in, duty_bus.G_duty_in, duty_bus.B_duty_in};
            pend_flag_d = 1'b1;
        end else if (xfer_c) begin
            pend_flag_d = 1'b0;
        end

        // Compare against next-cycle counter and duty so the edge lands with the tick.
        pwm_on_c[2] = en && (pcnt_d < active_d[3*DUTY_W-1:2*DUTY_W]);
        pwm_on_c[1] = en && (pcnt_d < active_d[2*DUTY_W-1:DUTY_W]);
        pwm_on_c[0] = en && (pcnt_d < active_d[DUTY_W-1:0]);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            psc_q                 <= '0;
            pcnt_q                <= '0;
            pend_q                <= '0;
            pend_flag_q           <= 1'b0;
            active_q              <= '0;
            {pwm_r, pwm_g, pwm_b} <= PWM_OFF;
            frame_start           <= 1'b0;
            duty_bus.duty_ack     <= 1'b0;
        end else begin
            psc_q                 <= psc_d;
            pcnt_q                <= pcnt_d;
            pend_q                <= pend_d;
            pend_flag_q           <= pend_flag_d;
            active_q              <= active_d;
            {pwm_r, pwm_g, pwm_b} <= pwm_on_c ^ PWM_OFF;
            frame_start           <= frame_go_c;
            duty_bus.duty_ack     <= xfer_c;
        end
    end
endmodule

// File: tb/tb_rgb_pwm_encoder.sv
// Self-checking bench for rgb_pwm_encoder (PRESCALE = 2, frame = 510 clks).
module tb_rgb_pwm_encoder;
    localparam int unsigned P     = 2;
    localparam int          FRAME = 255 * P;
`ifdef RGB_PWM_ACTIVE_LOW_EN
    localparam logic ON_LVL = 1'b0;
`else
    localparam logic ON_LVL = 1'b1;
`endif
    localparam logic       OFF_LVL = ~ON_LVL;
    localparam logic [2:0] OFF3    = {3{OFF_LVL}};

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic pwm_r, pwm_g, pwm_b, frame_start;

    rgb_pwm_encoder_if bus ();

    rgb_pwm_encoder #(.PRESCALE(P)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .duty_bus   (bus.slave),
        .pwm_r      (pwm_r),
        .pwm_g      (pwm_g),
        .pwm_b      (pwm_b),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one cycle index within the frame, duty compared in ticks.
    bit         m_init = 1'b0;
    bit         m_run  = 1'b0;
    int         m_pos  = 0;
    bit         m_pend = 1'b0;
    logic [7:0] m_act  [3];
    logic [7:0] m_pv   [3];
    logic [4:0] exp_v  = '0;

    always @(posedge clk) begin
        bit         start, xfer;
        logic [7:0] din [3];
        logic [2:0] lvl;
        din[0] = bus.R_duty_in;
        din[1] = bus.G_duty_in;
        din[2] = bus.B_duty_in;
        start  = 1'b0;
        xfer   = 1'b0;
        if (!rst) begin
            m_run  = 1'b0;
            m_pos  = 0;
            m_pend = 1'b0;
            for (int c = 0; c < 3; c++) begin
                m_act[c] = 8'd0;
                m_pv[c]  = 8'd0;
            end
            exp_v = {OFF3, 2'b00};
        end else begin
            if (!en) begin
                m_run = 1'b0;
            end else if (!m_run) begin
                m_run = 1'b1;
                m_pos = 0;
                start = 1'b1;
            end else begin
                m_pos++;
                if (m_pos == FRAME) begin
                    m_pos = 0;
                    start = 1'b1;
                end
            end
            xfer = m_pend && (start || !en);
            if (xfer) for (int c = 0; c < 3; c++) m_act[c] = m_pv[c];
            if (bus.duty_valid) begin
                for (int c = 0; c < 3; c++) m_pv[c] = din[c];
                m_pend = 1'b1;
            end else if (xfer) begin
                m_pend = 1'b0;
            end
            for (int c = 0; c < 3; c++)
                lvl[2-c] = (en && ((m_pos / int'(P)) < int'(m_act[c]))) ? ON_LVL : OFF_LVL;
            exp_v = {lvl, start, xfer};
        end
        m_init = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Advance to the next falling edge and compare every output with the model.
    task automatic step();
        @(negedge clk);
        if (m_init) begin
            n_checks++;
            if ({pwm_r, pwm_g, pwm_b, frame_start, bus.duty_ack} === exp_v) n_pass++;
            else $display("FAIL cycle_compare t=%0t: got rgb/fs/ack=%b, expected %b",
                          $time, {pwm_r, pwm_g, pwm_b, frame_start, bus.duty_ack}, exp_v);
        end
    endtask

    function automatic logic [7:0] rnd_duty();
        case ($urandom_range(0, 5))
            0:       return 8'd0;
            1:       return 8'd255;
            2:       return 8'd1;
            3:       return 8'd254;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic logic [23:0] gb(input logic [7:0] r);
        return {r, rnd_duty(), rnd_duty()};
    endfunction

    task automatic drive(input logic v, input logic [23:0] d);
        bus.duty_valid = v;
        {bus.R_duty_in, bus.G_duty_in, bus.B_duty_in} = d;
    endtask

    // Runs len cycles starting at a frame-start cycle, with up to two writes.
    task automatic frame_run(input int len, input int wa, input logic [23:0] va,
                             input int wb, input logic [23:0] vb,
                             output int hr, output int hg, output int hb,
                             output int fs0, output int ack0, output int ex);
        hr = 0; hg = 0; hb = 0; fs0 = 0; ack0 = 0; ex = 0;
        for (int i = 0; i < len; i++) begin
            hr += (pwm_r === ON_LVL) ? 1 : 0;
            hg += (pwm_g === ON_LVL) ? 1 : 0;
            hb += (pwm_b === ON_LVL) ? 1 : 0;
            if (i == 0) begin
                fs0  = (frame_start === 1'b1) ? 1 : 0;
                ack0 = (bus.duty_ack === 1'b1) ? 1 : 0;
            end else begin
                ex += ((frame_start === 1'b1) ? 1 : 0) + ((bus.duty_ack === 1'b1) ? 1 : 0);
            end
            if (i == wa)      drive(1'b1, va);
            else if (i == wb) drive(1'b1, vb);
            else              drive(1'b0, 24'($urandom));
            step();
        end
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hr, hg, hb, fs0, ack0, ex, acks;
        rst = 1'b0;
        en  = 1'b0;
        drive(1'b0, 24'd0);

        // Reset and first load
        repeat (4) begin
            step();
            check("reset_outputs", {pwm_r, pwm_g, pwm_b, frame_start, bus.duty_ack}, {OFF3, 2'b00});
        end
        rst = 1'b1;
        en  = 1'b1;
        drive(1'b1, {8'd255, 8'd60, 8'd0});
        step();
        frame_run(FRAME, -1, 24'd0, -1, 24'd0, hr, hg, hb, fs0, ack0, ex);
        check("f1_frame_start", fs0, 1);
        check("f1_ack", ack0, 0);
        check("f1_r_high", hr, 0);
        check("f1_g_high", hg, 0);
        frame_run(FRAME, 10, gb(8'd100), -1, 24'd0, hr, hg, hb, fs0, ack0, ex);
        check("f2_ack", ack0, 1);
        check("f2_frame_start", fs0, 1);
        check("f2_r_high", hr, 510);
        check("f2_g_high", hg, 120);
        check("f2_b_high", hb, 0);
        check("f2_extra_pulses", ex, 0);

        // Mid-frame update: active 100, write 8 at pcnt = 50
        frame_run(FRAME, 100, gb(8'd8), -1, 24'd0, hr, hg, hb, fs0, ack0, ex);
        check("f3_ack", ack0, 1);
        check("f3_r_high", hr, 200);
        // Back-to-back writes: 160 then 32, only 32 takes effect
        frame_run(FRAME, 20, gb(8'd160), 300, gb(8'd32), hr, hg, hb, fs0, ack0, ex);
        check("f4_ack", ack0, 1);
        check("f4_r_high", hr, 16);
        check("f4_extra_pulses", ex, 0);
        // Write 120 mid-frame, then 40 on the boundary cycle
        frame_run(FRAME, 100, gb(8'd120), FRAME - 1, gb(8'd40), hr, hg, hb, fs0, ack0, ex);
        check("f5_ack", ack0, 1);
        check("f5_r_high", hr, 64);
        check("f5_extra_pulses", ex, 0);
        frame_run(FRAME, -1, 24'd0, -1, 24'd0, hr, hg, hb, fs0, ack0, ex);
        check("f6_ack", ack0, 1);
        check("f6_r_high", hr, 240);
        check("f6_extra_pulses", ex, 0);

        // Enable toggle: 77 pending when en drops at frame position 50
        frame_run(50, 0, gb(8'd77), -1, 24'd0, hr, hg, hb, fs0, ack0, ex);
        check("f7_ack_collided_value", ack0, 1);
        check("f7_r_high_partial", hr, 50);
        en = 1'b0;
        drive(1'b0, 24'($urandom));
        step();
        check("en_low_outputs", {pwm_r, pwm_g, pwm_b, frame_start}, {OFF3, 1'b0});
        check("en_low_ack", bus.duty_ack, 1);
        acks = 0;
        repeat (4) begin
            step();
            acks += (bus.duty_ack === 1'b1) ? 1 : 0;
        end
        check("en_low_extra_acks", acks, 0);
        en = 1'b1;
        step();
        check("reenable_frame_start", frame_start, 1);
        check("reenable_ack", bus.duty_ack, 0);
        frame_run(FRAME, 5, gb(8'd255), -1, 24'd0, hr, hg, hb, fs0, ack0, ex);
        check("f8_r_high", hr, 154);
        check("f8_extra_pulses", ex, 0);

        // Reset mid-frame at pcnt = 120 with R = 255
        frame_run(240, -1, 24'd0, -1, 24'd0, hr, hg, hb, fs0, ack0, ex);
        check("f9_full_frame_start", fs0, 1);
        check("f9_ack", ack0, 1);
        check("f9_r_before_reset", pwm_r, ON_LVL);
        rst = 1'b0;
        step();
        check("midreset_outputs", {pwm_r, pwm_g, pwm_b, frame_start, bus.duty_ack}, {OFF3, 2'b00});
        step();
        rst = 1'b1;
        step();
        check("post_reset_frame_start", frame_start, 1);
        frame_run(FRAME, -1, 24'd0, -1, 24'd0, hr, hg, hb, fs0, ack0, ex);
        check("f10_r_high", hr, 0);
        check("f10_gb_high", hg + hb, 0);
        frame_run(FRAME, -1, 24'd0, -1, 24'd0, hr, hg, hb, fs0, ack0, ex);
        check("f11_ack_none_pending", ack0, 0);
        check("f11_r_high", hr, 0);

        // Randomized traffic: writes, enable toggles, occasional reset
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0) drive(1'b1, {rnd_duty(), rnd_duty(), rnd_duty()});
            else                           drive(1'b0, 24'($urandom));
            if ($urandom_range(0, 599) == 0) en = ~en;
            rst = ($urandom_range(0, 1499) != 0);
            step();
        end
        rst = 1'b1;
        en  = 1'b1;
        drive(1'b0, 24'd0);
        repeat (1100) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
